// File: rtl/arbitro_multiplexor_pkg.sv
// Shared types for the two-requester mux arbiter: state encoding and grant helpers.
package arbitro_multiplexor_pkg;

  typedef enum logic [1:0] {
    LIBRE    = 2'b00,
    CONCEDE0 = 2'b01,
    CONCEDE1 = 2'b10,
    CAMBIO   = 2'b11
  } estado_t;

  function automatic estado_t concede(input logic idx);
    return idx ? CONCEDE1 : CONCEDE0;
  endfunction

  function automatic logic [1:0] una_caliente(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/arbitro_multiplexor_contador_tenencia.sv
// Saturating tenure counter: clear has priority, counts up to MAX_TENENCIA-1 and holds.
module contador_tenencia #(
  parameter int unsigned MAX_TENENCIA = 8,
  parameter int unsigned CW           = $clog2(MAX_TENENCIA)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cuenta
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cuenta <= '0;
    else if (clr)
      cuenta <= '0;
    else if (en && cuenta != CW'(MAX_TENENCIA - 1))
      cuenta <= cuenta + CW'(1);
  end

endmodule

// File: rtl/arbitro_multiplexor.sv
// Round-robin arbiter for the shared 2-to-1 mux; the select only moves while no grant is held.
module arbitro_multiplexor
  import arbitro_multiplexor_pkg::*;
#(
  parameter  int unsigned MAX_TENENCIA = 8,
  localparam int unsigned CW           = $clog2(MAX_TENENCIA)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    solicitud,
  output logic [1:0]    concesion,
  output logic          seleccion,
  output logic          ocupado,
  output logic          expirado,
  output logic [CW-1:0] tenencia
);

  estado_t estado, estado_sig;
  logic    ultimo;
  logic    objetivo, objetivo_sig;
  logic    expira_sig;
  logic    dueno;
  logic    cnt_en;

  always_comb begin
    estado_sig   = estado;
    objetivo_sig = objetivo;
    expira_sig   = 1'b0;
    dueno        = (estado == CONCEDE1);
    case (estado)
      LIBRE: begin
        case (solicitud)
          2'b01:   estado_sig = CONCEDE0;
          2'b10:   estado_sig = CONCEDE1;
          2'b11:   estado_sig = concede(~ultimo);
          default: estado_sig = LIBRE;
        endcase
      end
      CONCEDE0, CONCEDE1: begin
        if (!solicitud[dueno] && solicitud[~dueno]) begin
          estado_sig   = CAMBIO;
          objetivo_sig = ~dueno;
        end else if (!solicitud[dueno]) begin
          estado_sig = LIBRE;
        end else if (tenencia == CW'(MAX_TENENCIA - 1) && solicitud[~dueno]) begin
          estado_sig   = CAMBIO;
          objetivo_sig = ~dueno;
          expira_sig   = 1'b1;
        end
      end
      CAMBIO: begin
        if (solicitud[objetivo])
          estado_sig = concede(objetivo);
        else if (solicitud[~objetivo])
          estado_sig = concede(~objetivo);
        else
          estado_sig = LIBRE;
      end
      default: estado_sig = LIBRE;
    endcase
  end

  // Count only while the same grant continues; any entry, guard or idle cycle restarts at 0.
  assign cnt_en = (estado == CONCEDE0 || estado == CONCEDE1) && (estado_sig == estado);

  contador_tenencia #(
    .MAX_TENENCIA(MAX_TENENCIA),
    .CW          (CW)
  ) u_contador (
    .clk   (clk),
    .rst   (rst),
    .clr   (~cnt_en),
    .en    (cnt_en),
    .cuenta(tenencia)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado    <= LIBRE;
      concesion <= '0;
      seleccion <= 1'b0;
      ocupado   <= 1'b0;
      expirado  <= 1'b0;
      ultimo    <= 1'b1;
      objetivo  <= 1'b0;
    end else begin
      estado   <= estado_sig;
      objetivo <= objetivo_sig;
      expirado <= expira_sig;
      ocupado  <= (estado_sig != LIBRE);
      case (estado_sig)
        CONCEDE0, CONCEDE1: begin
          concesion <= una_caliente(estado_sig == CONCEDE1);
          seleccion <= (estado_sig == CONCEDE1);
          ultimo    <= (estado_sig == CONCEDE1);
        end
        CAMBIO: begin
          concesion <= '0;
          seleccion <= objetivo_sig;
        end
        default: concesion <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_multiplexor.sv
// Scoreboard bench for arbitro_multiplexor: an owner/guard model predicts each cycle's outputs.
module tb_arbitro_multiplexor;

  localparam int MAX = 8;
  localparam int CW  = $clog2(MAX);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    solicitud = 2'b00;
  logic [1:0]    concesion;
  logic          seleccion, ocupado, expirado;
  logic [CW-1:0] tenencia;

  arbitro_multiplexor #(.MAX_TENENCIA(MAX)) dut (
    .clk      (clk),
    .rst      (rst),
    .solicitud(solicitud),
    .concesion(concesion),
    .seleccion(seleccion),
    .ocupado  (ocupado),
    .expirado (expirado),
    .tenencia (tenencia)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    conc;
    logic          sel;
    logic          ocup;
    logic          exp;
    logic [CW-1:0] ten;
  } salida_t;

  salida_t cola[$];
  int vectors = 0;
  int miscompares = 0;

  // Model: owner (-1 none), pending hand-off target (-1 none), cycles held, last owner.
  int   owner = -1, guard = -1, held = 0, last = 1;
  logic m_sel = 1'b0;

  logic [1:0] prev_conc = 2'b00;
  logic       prev_sel  = 1'b0;

  task automatic cmp(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic modelo_reset();
    owner = -1; guard = -1; held = 0; last = 1; m_sel = 1'b0;
  endtask

  task automatic dar(input int i);
    owner = i; held = 0; last = i;
  endtask

  task automatic modelo(input logic [1:0] s);
    salida_t e;
    int t, o;
    e = '0;
    if (guard >= 0) begin
      t = guard; guard = -1;
      if (s[t]) dar(t);
      else if (s[1-t]) dar(1 - t);
    end else if (owner < 0) begin
      if (s == 2'b11) dar(1 - last);
      else if (s[0]) dar(0);
      else if (s[1]) dar(1);
    end else begin
      o = owner;
      if (!s[o]) begin
        owner = -1;
        if (s[1-o]) guard = 1 - o;
      end else if (held == MAX - 1 && s[1-o]) begin
        owner = -1; guard = 1 - o; e.exp = 1'b1;
      end else if (held < MAX - 1) begin
        held++;
      end
    end
    if (guard >= 0) m_sel = (guard == 1);
    else if (owner >= 0) m_sel = (owner == 1);
    e.conc = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    e.sel  = m_sel;
    e.ocup = (owner >= 0) || (guard >= 0);
    e.ten  = (owner >= 0) ? CW'(held) : '0;
    cola.push_back(e);
  endtask

  // Called at a falling edge: drive, predict the result of the next rising edge, move on.
  task automatic ciclo(input logic [1:0] s);
    solicitud = s;
    modelo(s);
    @(negedge clk);
  endtask

  task automatic comprobar_reset();
    cmp("rst_concesion", concesion, 0);
    cmp("rst_seleccion", seleccion, 0);
    cmp("rst_ocupado",   ocupado,   0);
    cmp("rst_expirado",  expirado,  0);
    cmp("rst_tenencia",  tenencia,  0);
  endtask

  task automatic pulso_reset();
    #2 rst = 1'b1;
    #1 comprobar_reset();
    modelo_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : monitor
    salida_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (cola.size() == 0) begin
          cmp("sb_underflow", 0, 1);
        end else begin
          e = cola.pop_front();
          cmp("concesion", concesion, e.conc);
          cmp("seleccion", seleccion, e.sel);
          cmp("ocupado",   ocupado,   e.ocup);
          cmp("expirado",  expirado,  e.exp);
          cmp("tenencia",  tenencia,  e.ten);
        end
        cmp("conc_not_11", (concesion == 2'b11), 0);
        if (prev_conc != 2'b00 && concesion != 2'b00)
          cmp("sel_stable_in_grant", seleccion, prev_sel);
      end
      prev_conc = concesion;
      prev_sel  = seleccion;
    end
  end

  initial begin : driver
    logic [1:0] s;
    rst = 1'b1;
    solicitud = 2'b00;
    repeat (2) @(negedge clk);
    comprobar_reset();
    rst = 1'b0;
    modelo_reset();

    ciclo(2'b01); ciclo(2'b01); ciclo(2'b00); ciclo(2'b00);
    repeat (14) ciclo(2'b11);
    ciclo(2'b00); ciclo(2'b00);
    ciclo(2'b01); repeat (3) ciclo(2'b11);
    repeat (4) ciclo(2'b10);
    ciclo(2'b00); ciclo(2'b00);
    repeat (20) ciclo(2'b01);
    ciclo(2'b00); ciclo(2'b00);
    ciclo(2'b01); ciclo(2'b11); ciclo(2'b10); ciclo(2'b01); ciclo(2'b01);
    ciclo(2'b00); ciclo(2'b00);
    repeat (4) ciclo(2'b10);
    pulso_reset();
    ciclo(2'b11); ciclo(2'b11); ciclo(2'b00); ciclo(2'b00);

    s = 2'b00;
    for (int i = 0; i < 500; i++) begin
      for (int b = 0; b < 2; b++)
        if ($urandom_range(0, 4) == 0) s[b] = ~s[b];
      if (i == 250) pulso_reset();
      ciclo(s);
    end
    ciclo(2'b00);
    cmp("sb_drain", cola.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
